// File: rtl/irq_controller.sv
// Interrupt controller for the single-cycle CPU: edge-latched sources with fixed priority
// and a request/service handshake that tracks handler entry and exit through PC[31].
module irq_controller #(
  parameter int unsigned N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             pc31,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq_out
);

  localparam int unsigned ID_W = 4;
  localparam logic [1:0]  OFF_PEND  = 2'd0;
  localparam logic [1:0]  OFF_MASK  = 2'd1;
  localparam logic [1:0]  OFF_CTRL  = 2'd2;
  localparam logic [1:0]  OFF_TAKEN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] ovf_q, ovf_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             gie_q, gie_d;
  logic             taken_valid_q, taken_valid_d;
  logic [ID_W-1:0]  taken_id_q, taken_id_d;
  logic             pc31_q;

  logic [N_SRC-1:0] rise_c;
  logic [N_SRC-1:0] act_vec_c;
  logic             act_valid_c;
  logic [ID_W-1:0]  act_id_c;
  logic             wr_pend_c, wr_mask_c, wr_ctrl_c;
  logic             unused_ok;

  assign unused_ok = ^{addr[1:0], wdata};

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign rise_c    = s2_q & ~s3_q;
  assign wr_pend_c = wr & hit & (addr[3:2] == OFF_PEND);
  assign wr_mask_c = wr & hit & (addr[3:2] == OFF_MASK);
  assign wr_ctrl_c = wr & hit & (addr[3:2] == OFF_CTRL);

  // Fixed priority: lowest active index wins.
  assign act_vec_c   = pend_q & mask_q;
  assign act_valid_c = |act_vec_c;
  always_comb begin
    act_id_c = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act_vec_c[i]) act_id_c = ID_W'(i);
    end
  end

  assign irq_out = gie_q & act_valid_c & ~pc31 & ~taken_valid_q;

  // Register updates: a new edge always beats a same-cycle W1C.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    mask_d = mask_q;
    gie_d  = gie_q;
    if (wr_pend_c) begin
      pend_d = pend_q & ~wdata[N_SRC-1:0];
      ovf_d  = ovf_q & ~wdata[16 +: N_SRC];
    end
    ovf_d  = ovf_d | (rise_c & pend_q);
    pend_d = pend_d | rise_c;
    if (wr_mask_c) mask_d = wdata[N_SRC-1:0];
    if (wr_ctrl_c) gie_d = wdata[0];
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      pend_q        <= '0;
      ovf_q         <= '0;
      mask_q        <= '0;
      gie_q         <= 1'b0;
      taken_valid_q <= 1'b0;
      taken_id_q    <= '0;
      pc31_q        <= 1'b0;
    end else begin
      s1_q          <= src;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      pend_q        <= pend_d;
      ovf_q         <= ovf_d;
      mask_q        <= mask_d;
      gie_q         <= gie_d;
      taken_valid_q <= taken_valid_d;
      taken_id_q    <= taken_id_d;
      pc31_q        <= pc31;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (irq_out) state_d = ST_REQ;
      ST_REQ: begin
        if (pc31)          state_d = ST_SERVICE;
        else if (!irq_out) state_d = ST_IDLE;
      end
      ST_SERVICE: if (pc31_q && !pc31) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture the winning id on handler entry; release on handler return.
  always_comb begin
    taken_valid_d = taken_valid_q;
    taken_id_d    = taken_id_q;
    if (state_q == ST_REQ && pc31) begin
      taken_valid_d = 1'b1;
      taken_id_d    = act_id_c;
    end else if (state_q == ST_SERVICE && pc31_q && !pc31) begin
      taken_valid_d = 1'b0;
      taken_id_d    = '0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (addr[3:2])
        OFF_PEND:  rdata = 32'(pend_q) | (32'(ovf_q) << 16);
        OFF_MASK:  rdata = 32'(mask_q);
        OFF_CTRL:  rdata = {23'h0, act_valid_c, act_id_c, 3'h0, gie_q};
        OFF_TAKEN: rdata = {taken_valid_q, 27'h0, taken_id_q};
        default:   rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed and random bus/source/pc31 activity against a
// cycle-level reference model; every bus read is scored by an independent monitor.
module tb_irq_controller;

  localparam int NS = 4;
  localparam logic [31:0] BASE    = 32'h4000_0030;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_MASK  = BASE + 32'h4;
  localparam logic [31:0] A_CTRL  = BASE + 32'h8;
  localparam logic [31:0] A_TAKEN = BASE + 32'hC;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [NS-1:0] src;
  logic          pc31, rd, wr;
  logic [31:0]   addr, wdata, rdata;
  logic          hit, irq_out;

  irq_controller #(.N_SRC(NS), .BASE_ADDR(BASE)) dut (
    .sysclk(sysclk), .reset(reset), .src(src), .pc31(pc31), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .irq_out(irq_out)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  // Reference model state: what software would observe, updated once per clock.
  logic [NS-1:0] m_pend, m_ovf, m_mask;
  logic          m_gie, m_tv;
  logic [3:0]    m_tid;
  logic          m_last_irq, m_last_pc31;
  logic [NS-1:0] hist[$];

  function automatic logic in_win(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [3:0] m_act_id();
    for (int i = 0; i < NS; i++) if (m_pend[i] && m_mask[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic m_irq(input logic p);
    return m_gie && ((m_pend & m_mask) != '0) && !p && !m_tv;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic av;
    av = (m_pend & m_mask) != '0;
    if (!in_win(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return 32'(m_pend) + (32'(m_ovf) * 32'h1_0000);
      2'd1:    return 32'(m_mask);
      2'd2:    return (32'(av) << 8) | (32'(m_act_id()) << 4) | 32'(m_gie);
      default: return m_tv ? (32'h8000_0000 | 32'(m_tid)) : 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_ovf = '0; m_mask = '0; m_gie = 1'b0; m_tv = 1'b0; m_tid = '0;
    m_last_irq = 1'b0; m_last_pc31 = 1'b0;
    hist.delete();
    repeat (3) hist.push_front('0);
  endfunction

  // A source first seen high at edge k (low at k-1) becomes pending at edge k+2.
  function automatic void model_step();
    logic [NS-1:0] ev, np, no;
    logic          cur_irq;
    logic [3:0]    aid;
    cur_irq = m_irq(pc31);
    aid     = m_act_id();
    hist.push_front(src);
    ev = hist[2] & ~hist[3];
    while (hist.size() > 4) void'(hist.pop_back());
    np = m_pend;
    no = m_ovf;
    if (wr && in_win(addr) && addr[3:2] == 2'd0) begin
      np = np & ~wdata[NS-1:0];
      no = no & ~wdata[16 +: NS];
    end
    no = no | (ev & m_pend);
    np = np | ev;
    if (wr && in_win(addr) && addr[3:2] == 2'd1) m_mask = wdata[NS-1:0];
    if (wr && in_win(addr) && addr[3:2] == 2'd2) m_gie = wdata[0];
    // CPU saw irq_out last cycle and is now in the handler.
    if (m_last_irq && pc31) begin
      m_tv = 1'b1; m_tid = aid;
    end else if (m_tv && m_last_pc31 && !pc31) begin
      m_tv = 1'b0; m_tid = '0;
    end
    m_pend = np;
    m_ovf  = no;
    m_last_irq  = cur_irq;
    m_last_pc31 = pc31;
  endfunction

  task automatic cycle();
    @(posedge sysclk);
    if (!reset) model_reset();
    else        model_step();
    #1;
  endtask

  function automatic void push_exp(input string nm);
    exp_t e;
    e.nm = nm; e.rdata = m_rdata(addr); e.hit = in_win(addr); e.irq = m_irq(pc31);
    q.push_back(e);
  endfunction

  task automatic rd_chk(input logic [31:0] a, input string nm);
    rd = 1'b1; addr = a;
    push_exp(nm);
    cycle();
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  task automatic pulse(input logic [NS-1:0] v, input int gap);
    src = v;
    cycle();
    src = '0;
    repeat (gap) cycle();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_reset();
    rd_chk(A_PEND, "rst_pend");
    rd_chk(A_TAKEN, "rst_taken");
    reset = 1'b1;
  endtask

  // Scoreboard monitor: scores each read away from the active edge.
  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (rd) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read got=%08h", rdata);
      end else begin
        e = q.pop_front();
        total += 3;
        if (rdata !== e.rdata) begin
          bad++; $display("FAIL %s rdata got=%08h want=%08h", e.nm, rdata, e.rdata);
        end
        if (hit !== e.hit) begin
          bad++; $display("FAIL %s hit got=%0b want=%0b", e.nm, hit, e.hit);
        end
        if (irq_out !== e.irq) begin
          bad++; $display("FAIL %s irq_out got=%0b want=%0b", e.nm, irq_out, e.irq);
        end
      end
    end
    if (end_req && !end_ack) begin
      total++;
      if (q.size() != 0) begin
        bad++; $display("FAIL leftover_expect got=%0d want=0", q.size());
      end
      end_ack = 1'b1;
    end
  end

  initial begin
    reset = 1'b0; src = '0; pc31 = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_reset();
    @(posedge sysclk); #1;
    rd_chk(A_PEND, "reset_pend");
    rd_chk(A_MASK, "reset_mask");
    rd_chk(A_CTRL, "reset_ctrl");
    rd_chk(A_TAKEN, "reset_taken");
    reset = 1'b1;

    // Single source request and priority id
    wr_reg(A_MASK, 32'hF);
    wr_reg(A_CTRL, 32'h1);
    pulse(4'h4, 2);
    rd_chk(A_PEND, "src2_pend");
    rd_chk(A_CTRL, "src2_ctrl");

    // Handler entry / exit with two pending sources
    wr_reg(A_PEND, 32'h4);
    pulse(4'hA, 3);
    pc31 = 1'b1;
    cycle();
    rd_chk(A_TAKEN, "taken_entry");
    wr_reg(A_PEND, 32'h2);
    pc31 = 1'b0;
    cycle();
    rd_chk(A_TAKEN, "taken_exit");
    rd_chk(A_CTRL, "rereq_id3");

    // Overflow and its clear
    wr_reg(A_PEND, 32'hFFFF_FFFF);
    pulse(4'h1, 3);
    pulse(4'h1, 3);
    rd_chk(A_PEND, "ovf_set");
    wr_reg(A_PEND, 32'h0001_0001);
    rd_chk(A_PEND, "ovf_clr");

    // W1C coinciding with the edge
    src = 4'h1; cycle(); src = '0; cycle();
    wr_reg(A_PEND, 32'h1);
    rd_chk(A_PEND, "set_beats_w1c");

    // Exception entry with no request pending
    wr_reg(A_PEND, 32'hFFFF_FFFF);
    repeat (2) cycle();
    pc31 = 1'b1; cycle(); cycle(); pc31 = 1'b0; cycle();
    rd_chk(A_TAKEN, "illop_taken");

    // Reset while servicing
    pulse(4'h1, 4);
    pc31 = 1'b1;
    cycle();
    rd_chk(A_TAKEN, "svc_taken");
    reset_pulse();
    pc31 = 1'b0;
    rd_chk(A_MASK, "post_rst_mask");

    // Global disable and out-of-window access
    wr_reg(A_MASK, 32'hF);
    wr_reg(A_CTRL, 32'h0);
    pulse(4'h2, 3);
    rd_chk(A_PEND, "gie_off");
    rd_chk(32'h4000_0040, "out_of_window");
    wr_reg(A_CTRL, 32'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) src = NS'($urandom);
      if ($urandom_range(0, 7) == 0) pc31 = ~pc31;
      else if (m_irq(pc31) && $urandom_range(0, 2) == 0) pc31 = 1'b1;
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = BASE + 32'h10;
        default: addr = BASE + 32'($urandom_range(0, 3) * 4);
      endcase
      wdata = $urandom;
      if (addr == A_CTRL) wdata[0] = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 3) != 0);
      if (rd) push_exp("rand_rd");
      cycle();
      rd = 1'b0; wr = 1'b0;
      if ($urandom_range(0, 599) == 0) reset_pulse();
    end

    src = '0; pc31 = 1'b0;
    repeat (2) cycle();
    end_req = 1'b1;
    repeat (5) begin
      if (!end_ack) @(posedge sysclk);
    end
    if (!end_ack) begin
      $display("FAIL monitor_end got=0 want=1");
      $fatal(1, "monitor did not respond");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
